// File: rtl/chip_pkg.sv
// chip_pkg: shared tile geometry, pixel width and loader state encoding.
package chip_pkg;

  localparam int BIT_LENGTH_DEF = 4;
  localparam int TILE_BEATS_DEF = 80;
  localparam int TILE_DIM       = 20;
  localparam int LANES          = 5;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FULL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [8:0] pix_addr(
    input logic [4:0] row,
    input logic [4:0] col
  );
    return 9'(row) * 9'(TILE_DIM) + 9'(col);
  endfunction

endpackage

// File: rtl/tile_buf.sv
// tile_buf: 20x20 pixel store, 5-pixel write port, registered 1-pixel read.
module tile_buf
  import chip_pkg::*;
#(
  parameter int BIT_LENGTH = BIT_LENGTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [4:0]                       wr_row,
  input  logic [1:0]                       wr_seg,
  input  logic [LANES-1:0][BIT_LENGTH-1:0] wr_data,
  input  logic [4:0]                       rd_row,
  input  logic [4:0]                       rd_col,
  output logic [BIT_LENGTH-1:0]            rd_data
);

  logic [BIT_LENGTH-1:0] mem [TILE_DIM*TILE_DIM];
  logic [8:0]            wr_base;

  assign wr_base = pix_addr(wr_row, 5'(wr_seg) * 5'(LANES));

  always_ff @(posedge clk)
    if (wr_en)
      for (int k = 0; k < LANES; k++)
        mem[wr_base + 9'(k)] <= wr_data[k];

  // out-of-range addresses read as zero
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      rd_data <= '0;
    else if (rd_row < 5'(TILE_DIM) && rd_col < 5'(TILE_DIM))
      rd_data <= mem[pix_addr(rd_row, rd_col)];
    else
      rd_data <= '0;

endmodule

// File: rtl/tile_loader.sv
// tile_loader: streams 5-pixel beats into a 20x20 tile for random readout.
// Optional sticky load_err output when TILE_ERR_CHK_EN is defined.
module tile_loader
  import chip_pkg::*;
#(
  parameter int BIT_LENGTH = BIT_LENGTH_DEF,
  parameter int TILE_BEATS = TILE_BEATS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIT_LENGTH-1:0] pixel_in0,
  input  logic [BIT_LENGTH-1:0] pixel_in1,
  input  logic [BIT_LENGTH-1:0] pixel_in2,
  input  logic [BIT_LENGTH-1:0] pixel_in3,
  input  logic [BIT_LENGTH-1:0] pixel_in4,
  input  logic                  load_end,
  input  logic [4:0]            rd_row,
  input  logic [4:0]            rd_col,
  output logic [BIT_LENGTH-1:0] rd_data,
  output logic                  tile_valid,
  input  logic                  tile_release,
`ifdef TILE_ERR_CHK_EN
  output logic                  load_err,
`endif
  output logic [6:0]            beat_cnt
);

  state_t                          state;
  logic                            hold_end;
  logic                            wr_en;
  logic                            last_idx;
  logic                            last;
  logic [LANES-1:0][BIT_LENGTH-1:0] wr_data;

  assign wr_data  = {pixel_in4, pixel_in3, pixel_in2, pixel_in1, pixel_in0};
  assign last_idx = (beat_cnt == 7'(TILE_BEATS - 1));
  assign last     = load_end || last_idx;
  // load_end left high by the previous tile blocks intake until it drops
  assign wr_en    = (state == ST_LOAD) && !(hold_end && load_end);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= ST_LOAD;
      beat_cnt   <= '0;
      tile_valid <= 1'b0;
      hold_end   <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD:
          if (wr_en) begin
            beat_cnt <= beat_cnt + 7'd1;
            if (last) begin
              state      <= ST_FULL;
              tile_valid <= 1'b1;
            end
          end
        ST_FULL:
          if (tile_release) begin
            state      <= ST_DRAIN;
            beat_cnt   <= '0;
            tile_valid <= 1'b0;
            hold_end   <= 1'b1;
          end
        ST_DRAIN:
          state <= ST_LOAD;
        default:
          state <= ST_LOAD;
      endcase
      if (!load_end)
        hold_end <= 1'b0;
    end

`ifdef TILE_ERR_CHK_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      load_err <= 1'b0;
    else if (wr_en && (load_end != last_idx))
      load_err <= 1'b1;
`endif

  tile_buf #(
    .BIT_LENGTH(BIT_LENGTH)
  ) u_buf (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_row (beat_cnt[6:2]),
    .wr_seg (beat_cnt[1:0]),
    .wr_data(wr_data),
    .rd_row (rd_row),
    .rd_col (rd_col),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: directed stimulus with a tile-image model and literal pins.
module tb_tile_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] px [5];
  logic       load_end = 1'b0;
  logic [4:0] rd_row = '0;
  logic [4:0] rd_col = '0;
  logic [3:0] rd_data;
  logic       tile_valid;
  logic       tile_release = 1'b0;
  logic [6:0] beat_cnt;
`ifdef TILE_ERR_CHK_EN
  logic       load_err;
`endif

  int errors = 0;
  int checks = 0;

  int img [20][20];
  bit known [20][20];
  int m_cnt = 0;
  bit m_full = 0;
  bit m_drain = 0;
  bit m_hold = 0;
  int m_rd = 0;
  bit m_rd_ok = 1;

  tile_loader dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in0   (px[0]),
    .pixel_in1   (px[1]),
    .pixel_in2   (px[2]),
    .pixel_in3   (px[3]),
    .pixel_in4   (px[4]),
    .load_end    (load_end),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_data     (rd_data),
    .tile_valid  (tile_valid),
    .tile_release(tile_release),
`ifdef TILE_ERR_CHK_EN
    .load_err    (load_err),
`endif
    .beat_cnt    (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pix(input int pat, input int b, input int k);
    case (pat)
      0:       return 4'(b % 16);
      1:       return 4'((b + k) % 16);
      2:       return 4'((3 * b + k) % 16);
      3:       return 4'((b + 2 * k + 7) % 16);
      default: return 4'((5 * b + k) % 16);
    endcase
  endfunction

  // Model: a tile is a 20x20 image filled left-to-right, top-to-bottom
  always @(posedge clk) begin
    if (!reset) begin
      m_cnt = 0; m_full = 0; m_drain = 0; m_hold = 0;
      m_rd = 0; m_rd_ok = 1;
    end else begin
      if (rd_row < 20 && rd_col < 20) begin
        m_rd    = img[rd_row][rd_col];
        m_rd_ok = known[rd_row][rd_col];
      end else begin
        m_rd = 0; m_rd_ok = 1;
      end
      if (m_full) begin
        if (tile_release) begin
          m_full = 0; m_drain = 1; m_cnt = 0; m_hold = 1;
        end
      end else if (m_drain) begin
        m_drain = 0;
      end else if (!(m_hold && load_end)) begin
        for (int k = 0; k < 5; k++) begin
          img[m_cnt / 4][5 * (m_cnt % 4) + k]   = int'(px[k]);
          known[m_cnt / 4][5 * (m_cnt % 4) + k] = 1;
        end
        m_cnt++;
        if (load_end || m_cnt == 80) m_full = 1;
      end
      if (!load_end) m_hold = 0;
    end
    #1;
    chk("tile_valid", int'(tile_valid), int'(m_full));
    chk("beat_cnt", int'(beat_cnt), m_cnt);
    if (m_rd_ok) chk("rd_data", int'(rd_data), m_rd);
  end

  task automatic load_tile(input int n, input int pat, input bit end_last);
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 5; k++) px[k] = pix(pat, b, k);
      load_end = end_last && (b == n - 1);
      if (b == n - 1) chk("valid_before_last", int'(tile_valid), 0);
      @(negedge clk);
    end
  endtask

  task automatic rd(input int r, input int c, input string name, input int exp);
    rd_row = 5'(r); rd_col = 5'(c);
    @(negedge clk);
    chk(name, int'(rd_data), exp);
  endtask

  task automatic release_tile();
    tile_release = 1'b1;
    @(negedge clk);
    tile_release = 1'b0;
    chk("valid_after_release", int'(tile_valid), 0);
    chk("cnt_after_release", int'(beat_cnt), 0);
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 5; k++) px[k] = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_cnt", int'(beat_cnt), 0);
    chk("reset_valid", int'(tile_valid), 0);
    chk("reset_rd", int'(rd_data), 0);
    reset = 1'b1;

    load_tile(80, 0, 1);
    chk("valid_at_81", int'(tile_valid), 1);
    chk("cnt_full", int'(beat_cnt), 80);
    rd(0, 0, "rd_0_0", 0);
    rd(19, 19, "rd_19_19", 15);
    rd(20, 3, "rd_oob", 0);

    repeat (20) begin
      for (int k = 0; k < 5; k++) px[k] = 4'($urandom);
      rd_row = 5'($urandom_range(0, 21));
      rd_col = 5'($urandom_range(0, 21));
      @(negedge clk);
    end
    chk("cnt_hold", int'(beat_cnt), 80);

    rd_row = 5'd19; rd_col = 5'd19;
    tile_release = 1'b1;
    @(negedge clk);
    tile_release = 1'b0;
    chk("rd_at_release", int'(rd_data), 15);
    chk("valid_drain", int'(tile_valid), 0);
    repeat (3) begin
      for (int k = 0; k < 5; k++) px[k] = 4'($urandom);
      @(negedge clk);
      chk("cnt_wait_end_low", int'(beat_cnt), 0);
    end

    load_tile(37, 1, 0);
    chk("cnt_37", int'(beat_cnt), 37);
    reset = 1'b0;
    #1;
    chk("mid_reset_cnt", int'(beat_cnt), 0);
    chk("mid_reset_valid", int'(tile_valid), 0);
    chk("mid_reset_rd", int'(rd_data), 0);
    @(negedge clk);
    reset = 1'b1;

    load_tile(80, 2, 1);
    chk("valid_tile2", int'(tile_valid), 1);
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 20; c++) begin
        rd_row = 5'(r); rd_col = 5'(c);
        @(negedge clk);
      end
    rd(5, 7, "rd_5_7", 1);

    release_tile();
    load_tile(80, 3, 0);
    chk("sat_valid", int'(tile_valid), 1);
    chk("sat_cnt", int'(beat_cnt), 80);
    repeat (5) begin
      for (int k = 0; k < 5; k++) px[k] = 4'($urandom);
      @(negedge clk);
    end
    chk("sat_cnt_hold", int'(beat_cnt), 80);
    rd(0, 0, "sat_rd_0_0", 7);
    rd(19, 19, "sat_rd_19_19", 14);

    release_tile();
    load_tile(51, 4, 1);
    chk("early_valid", int'(tile_valid), 1);
    chk("early_cnt", int'(beat_cnt), 51);
    rd(10, 6, "early_rd_10_6", 14);
`ifdef TILE_ERR_CHK_EN
    chk("load_err_set", int'(load_err), 1);
`endif
    release_tile();
    chk("idle_valid", int'(tile_valid), 0);
`ifdef TILE_ERR_CHK_EN
    chk("load_err_sticky", int'(load_err), 1);
`endif
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
